// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle FETCH/DECODE/EXEC/WB sequencer driving ALU, regfile, flag and PC strobes
module ctrl_seq #(
  parameter int INSTW = 16,
  parameter int OPW   = 4,
  parameter int ALUW  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [INSTW-1:0] i_inst,
  input  logic             i_fetch_ack,
  input  logic             i_stall,
  output logic             o_fetch_req,
  output logic [ALUW-1:0]  o_alu_do,
  output logic             o_alu_en,
  output logic             o_reg_we,
  output logic             o_flag_we,
  output logic             o_pc_inc,
  output logic             o_illegal,
  output logic [1:0]       o_state
);
  localparam logic [1:0] S_FETCH = 2'd0, S_DECODE = 2'd1, S_EXEC = 2'd2, S_WB = 2'd3;
  localparam logic [OPW-1:0] OP_MOV = 'd0, OP_ADD = 'd1, OP_SUB = 'd2, OP_ASR = 'd3,
                             OP_ASL = 'd4, OP_OR = 'd5, OP_AND = 'd6, OP_XOR = 'd7,
                             OP_LSL = 'd8, OP_LSR = 'd9, OP_CND = 'd10;
  localparam logic [ALUW-1:0] ALU_NOP = 'd0, ALU_MOV = 'd1, ALU_ADD = 'd2, ALU_SUB = 'd3,
                              ALU_ASR = 'd4, ALU_ASL = 'd5, ALU_OR = 'd6, ALU_AND = 'd7,
                              ALU_XOR = 'd8, ALU_LSL = 'd9, ALU_LSR = 'd10, ALU_CND = 'd11;
  logic [1:0]       r_state;
  logic [INSTW-1:0] r_inst;
  logic [OPW-1:0]   w_op;
  logic [ALUW-1:0]  w_alu;
  logic             w_legal;
  logic             w_unused;
  assign w_op     = r_inst[INSTW-1 -: OPW];
  assign w_unused = ^r_inst[INSTW-OPW-1:0];
  assign o_state  = r_state;
  always_comb begin
    w_alu   = ALU_NOP;
    w_legal = 1'b1;
    case (w_op)
      OP_MOV:  w_alu = ALU_MOV;
      OP_ADD:  w_alu = ALU_ADD;
      OP_SUB:  w_alu = ALU_SUB;
      OP_ASR:  w_alu = ALU_ASR;
      OP_ASL:  w_alu = ALU_ASL;
      OP_OR:   w_alu = ALU_OR;
      OP_AND:  w_alu = ALU_AND;
      OP_XOR:  w_alu = ALU_XOR;
      OP_LSL:  w_alu = ALU_LSL;
      OP_LSR:  w_alu = ALU_LSR;
      OP_CND:  w_alu = ALU_CND;
      default: w_legal = 1'b0;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_FETCH;
      r_inst      <= '0;
      o_alu_do    <= ALU_NOP;
      o_fetch_req <= 1'b0;
      o_pc_inc    <= 1'b0;
      o_alu_en    <= 1'b0;
      o_reg_we    <= 1'b0;
      o_flag_we   <= 1'b0;
      o_illegal   <= 1'b0;
    end else begin
      o_pc_inc  <= 1'b0;
      o_alu_en  <= 1'b0;
      o_reg_we  <= 1'b0;
      o_flag_we <= 1'b0;
      o_illegal <= 1'b0;
      case (r_state)
        S_FETCH:
          if (o_fetch_req && i_fetch_ack) begin
            r_inst      <= i_inst;
            o_fetch_req <= 1'b0;
            o_pc_inc    <= 1'b1;
            r_state     <= S_DECODE;
          end else begin
            o_fetch_req <= 1'b1;
          end
        S_DECODE:
          if (!i_stall) begin
            o_alu_do  <= w_alu;
            o_illegal <= !w_legal;
            r_state   <= w_legal ? S_EXEC : S_FETCH;
          end
        S_EXEC:
          if (!i_stall) begin
            o_alu_en <= 1'b1;
            r_state  <= S_WB;
          end
        default:
          if (!i_stall) begin
            o_flag_we <= w_op == OP_CND;
            o_reg_we  <= w_op != OP_CND;
            r_state   <= S_FETCH;
          end
      endcase
    end
  end
endmodule
